// File: rtl/lfsr_stream_if.sv
// Word-stream bus between an LFSR/parity source and the stream checker.
// The checker's status outputs are carried on the same bundle.
interface lfsr_stream_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic [7:0]       in_data;
    logic             clear_cnt;
    logic             locked;
    logic [1:0]       state;
    logic             par_err;
    logic             seq_err;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] word_count;

    modport master (
        output in_valid, in_data, clear_cnt,
        input  locked, state, par_err, seq_err, err_count, word_count
    );

    modport slave (
        input  in_valid, in_data, clear_cnt,
        output locked, state, par_err, seq_err, err_count, word_count
    );
endinterface

// File: rtl/lfsr_stream_checker.sv
// Parity and sequence checker for the x^7+x^6+1 LFSR word stream.
// Acquires lock by prediction, then flywheels the predictor and counts errors.
module lfsr_stream_checker #(
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 3,
    parameter int CNT_W      = 16
) (
    input  logic          clk,
    input  logic          rst,
    lfsr_stream_if.slave  bus
);
    typedef enum logic [1:0] {HUNT = 2'd0, SYNC = 2'd1, LOCK = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [6:0]       ref_q, ref_d;
    logic [3:0]       match_cnt_q, match_cnt_d;
    logic [3:0]       miss_cnt_q, miss_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic             par_err_q, par_err_d;
    logic             seq_err_q, seq_err_d;
    logic             locked_q, locked_d;

    logic [6:0] pred;
    logic [6:0] lfsr;
    logic       par_ok;
    logic       is_match;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

    always_comb begin
        pred        = {ref_q[5:0], ref_q[6] ^ ref_q[5]};
        lfsr        = bus.in_data[6:0];
        par_ok      = (bus.in_data[7] == ~^lfsr);
        // A zero field is the LFSR lock-up state and is never a legal word.
        is_match    = par_ok && (lfsr == pred) && (lfsr != 7'd0);

        state_d     = state_q;
        ref_d       = ref_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        err_cnt_d   = err_cnt_q;
        word_cnt_d  = word_cnt_q;
        par_err_d   = 1'b0;
        seq_err_d   = 1'b0;

        if (bus.in_valid) begin
            par_err_d = ~par_ok;
            unique case (state_q)
                HUNT: begin
                    if (par_ok && lfsr != 7'd0) begin
                        ref_d       = lfsr;
                        match_cnt_d = 4'd0;
                        state_d     = SYNC;
                    end
                end
                SYNC: begin
                    if (is_match) begin
                        ref_d       = lfsr;
                        match_cnt_d = match_cnt_q + 4'd1;
                        if (match_cnt_d == 4'(LOCK_COUNT)) begin
                            state_d    = LOCK;
                            miss_cnt_d = 4'd0;
                        end
                    end else begin
                        state_d = HUNT;
                    end
                end
                LOCK: begin
                    // Flywheel: the reference follows the prediction, not the input.
                    word_cnt_d = sat_inc(word_cnt_q);
                    ref_d      = pred;
                    if (is_match) begin
                        miss_cnt_d = 4'd0;
                    end else begin
                        seq_err_d  = par_ok;
                        err_cnt_d  = sat_inc(err_cnt_q);
                        miss_cnt_d = miss_cnt_q + 4'd1;
                        if (miss_cnt_d == 4'(LOSS_COUNT)) state_d = HUNT;
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        if (bus.clear_cnt) begin
            err_cnt_d  = '0;
            word_cnt_d = '0;
        end

        locked_d = (state_d == LOCK);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= HUNT;
            ref_q       <= 7'd0;
            match_cnt_q <= 4'd0;
            miss_cnt_q  <= 4'd0;
            err_cnt_q   <= '0;
            word_cnt_q  <= '0;
            par_err_q   <= 1'b0;
            seq_err_q   <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ref_q       <= ref_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            err_cnt_q   <= err_cnt_d;
            word_cnt_q  <= word_cnt_d;
            par_err_q   <= par_err_d;
            seq_err_q   <= seq_err_d;
            locked_q    <= locked_d;
        end
    end

    assign bus.state      = state_q;
    assign bus.locked     = locked_q;
    assign bus.par_err    = par_err_q;
    assign bus.seq_err    = seq_err_q;
    assign bus.err_count  = err_cnt_q;
    assign bus.word_count = word_cnt_q;
endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Directed and randomized bench for lfsr_stream_checker against a reference model.
// Narrow counters make saturation reachable in a short run.
module tb_lfsr_stream_checker;
    localparam int CW   = 4;
    localparam int LOCK = 4;
    localparam int LOSS = 3;
    localparam int SAT  = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    lfsr_stream_if #(.CNT_W(CW)) bus ();

    lfsr_stream_checker #(.LOCK_COUNT(LOCK), .LOSS_COUNT(LOSS), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errs   = 0;
    int checks = 0;

    // Reference model state.
    int         m_state;
    logic [6:0] m_ref;
    int         m_match, m_miss, m_err, m_words;
    bit         m_par, m_seq;
    logic [6:0] g;

    function automatic logic [6:0] nxt(input logic [6:0] r);
        int v;
        v = ((int'(r) * 2) % 128) + (((int'(r) / 64) + (int'(r) / 32)) % 2);
        return 7'(v);
    endfunction

    // Generator side: pick the parity bit so the whole byte has an odd number of ones.
    function automatic logic [7:0] mk(input logic [6:0] l);
        logic [7:0] b;
        b = {1'b0, l};
        if ($countones(b) % 2 == 0) b[7] = 1'b1;
        return b;
    endfunction

    task automatic model_reset();
        m_state = 0; m_ref = 7'd0; m_match = 0; m_miss = 0;
        m_err = 0; m_words = 0; m_par = 1'b0; m_seq = 1'b0;
    endtask

    task automatic model_step(input bit v, input logic [7:0] d, input bit clr);
        bit good, hit;
        logic [6:0] p;
        m_par = 1'b0; m_seq = 1'b0;
        if (v) begin
            good  = ($countones(d) % 2) == 1;
            p     = nxt(m_ref);
            hit   = good && (d[6:0] == p) && (d[6:0] != 7'd0);
            m_par = !good;
            if (m_state == 0) begin
                if (good && d[6:0] != 7'd0) begin m_ref = d[6:0]; m_match = 0; m_state = 1; end
            end else if (m_state == 1) begin
                if (hit) begin
                    m_ref = d[6:0]; m_match++;
                    if (m_match == LOCK) begin m_state = 2; m_miss = 0; end
                end else m_state = 0;
            end else begin
                if (m_words < SAT) m_words++;
                m_ref = p;
                if (hit) m_miss = 0;
                else begin
                    m_seq = good;
                    if (m_err < SAT) m_err++;
                    m_miss++;
                    if (m_miss == LOSS) m_state = 0;
                end
            end
        end
        if (clr) begin m_err = 0; m_words = 0; end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"},  32'(bus.state),      32'(m_state));
        chk({tag, ".locked"}, 32'(bus.locked),     32'(m_state == 2));
        chk({tag, ".par"},    32'(bus.par_err),    32'(m_par));
        chk({tag, ".seq"},    32'(bus.seq_err),    32'(m_seq));
        chk({tag, ".errc"},   32'(bus.err_count),  32'(m_err));
        chk({tag, ".words"},  32'(bus.word_count), 32'(m_words));
    endtask

    task automatic send(input string tag, input bit v, input logic [7:0] d, input bit clr);
        @(negedge clk);
        bus.in_valid = v; bus.in_data = d; bus.clear_cnt = clr;
        @(posedge clk);
        model_step(v, d, clr);
        #1 check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 8'h02; bus.clear_cnt = 1'b0;
        @(posedge clk);
        model_reset();
        #1 check_all(tag);
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b0;
    endtask

    task automatic acquire(input string tag);
        send(tag, 1, 8'h01, 0); send(tag, 1, 8'h02, 0); send(tag, 1, 8'h04, 0);
        send(tag, 1, 8'h08, 0); send(tag, 1, 8'h10, 0);
        g = 7'h10;
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.clear_cnt = 1'b0;
        model_reset();
        g = 7'h01;

        do_reset("reset");
        acquire("acq");
        chk("acq_locked", 32'(bus.locked), 32'd1);

        // Correct continuation with idle gaps in between.
        send("run", 1, 8'h20, 0);
        send("gap", 0, 8'h55, 0);
        send("run", 1, 8'hC1, 0);
        send("gap", 0, 8'hAA, 0);
        send("gap", 0, 8'h00, 0);
        send("run", 1, 8'h83, 0);
        chk("run_words", 32'(bus.word_count), 32'd3);
        g = 7'h03;

        // Bad parity on the expected value, then a clean word.
        g = nxt(g); send("badpar", 1, mk(g) ^ 8'h80, 0);
        g = nxt(g); send("recover", 1, mk(g), 0);

        // Good parity, wrong value: three misses drop lock.
        send("miss1", 1, 8'h85, 0);
        send("miss2", 1, 8'h85, 0);
        send("miss3", 1, 8'h85, 0);
        send("hold", 0, 8'h85, 0);

        // SYNC break, reseed, and the zero-field word.
        do_reset("reset2");
        send("sync", 1, 8'h01, 0);
        send("break", 1, 8'h03, 0);
        send("reseed", 1, 8'h04, 0);
        send("zero_sync", 1, 8'h80, 0);
        send("zero_hunt", 1, 8'h80, 0);

        // Clear coinciding with an erroring word.
        do_reset("reset3");
        acquire("acq3");
        send("clr_err", 1, 8'h85, 1);
        send("err_after", 1, 8'h85, 0);
        send("clr_idle", 0, 8'h00, 1);

        // Reset asserted while locked with a valid word present.
        do_reset("midlock_rst");

        // Saturation of word_count and err_count.
        acquire("acq4");
        for (int i = 0; i < 20; i++) begin
            g = nxt(g); send("sat_words", 1, mk(g), 0);
        end
        for (int i = 0; i < 10; i++) begin
            g = nxt(g); send("sat_e1", 1, mk(g) ^ 8'h80, 0);
            g = nxt(g); send("sat_e2", 1, mk(g) ^ 8'h01, 0);
            g = nxt(g); send("sat_ok", 1, mk(g), 0);
        end

        // Random stream with corruption, reseeds, gaps and clears.
        for (int i = 0; i < 800; i++) begin
            int r, k;
            logic [7:0] d;
            r = $urandom_range(0, 99);
            k = $urandom_range(0, 39);
            if (r < 85) begin
                g = nxt(g);
                if (k == 0)      d = mk(g) ^ 8'h80;
                else if (k == 1) d = 8'($urandom_range(0, 255));
                else if (k == 2) begin g = 7'($urandom_range(1, 127)); d = mk(g); end
                else             d = mk(g);
                send("rand", 1, d, ($urandom_range(0, 49) == 0));
            end else begin
                send("rand_idle", 0, 8'($urandom_range(0, 255)), ($urandom_range(0, 49) == 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
